// File: rtl/afifo_pkg.sv
// Shared helpers for the dual-clock FIFO controller: Gray conversion and sizing constants.
package afifo_pkg;

  localparam int MIN_SYNC_STAGES = 2;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; narrower pointers are zero-extended by the caller.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int s = 1; s < 32; s = s * 2) b = b ^ (b >> s);
    return b;
  endfunction

endpackage

// File: rtl/afifo_gray_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer; STAGES destination-clock edges of latency.
module afifo_gray_sync
  import afifo_pkg::*;
#(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (STAGES < MIN_SYNC_STAGES) begin : g_bad_stages
    $error("afifo_gray_sync: STAGES below minimum");
  end

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/afifo_ctl_lvl.sv
// Dual-clock FIFO control: Gray pointers, registered full/empty/almost flags, fill levels, error flags.
// Define AFIFO_ERR_STICKY_EN to make overflow/underflow hold until reset instead of pulsing.
module afifo_ctl_lvl
  import afifo_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AF_THRESH   = depth_of(ADDR_W) - 2,
  parameter int AE_THRESH   = 2
) (
  input  logic              reset_n,
  input  logic              r_clk,
  input  logic              w_clk,
  input  logic              wr,
  input  logic              rd,
  output logic [ADDR_W-1:0] addr_w,
  output logic [ADDR_W-1:0] addr_r,
  output logic              we_enable,
  output logic              rd_enable,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   w_level,
  output logic [ADDR_W:0]   r_level,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = depth_of(ADDR_W);
  localparam int PW    = ADDR_W + 1;

  if (ADDR_W < 2 || SYNC_STAGES < MIN_SYNC_STAGES || AE_THRESH <= 0 ||
      AF_THRESH <= AE_THRESH || AF_THRESH > DEPTH) begin : g_bad_cfg
    $error("afifo_ctl_lvl: illegal parameter set");
  end

  localparam logic [PW-1:0] AF_LVL = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_LVL = PW'(AE_THRESH);

  logic [PW-1:0] wbin, wgray, wbin_next, wgray_next, rq, rq_bin, w_level_next;
  logic [PW-1:0] rbin, rgray, rbin_next, rgray_next, wq, wq_bin, r_level_next;

  // write domain
  assign we_enable    = wr & ~full;
  assign wbin_next    = wbin + PW'(we_enable);
  assign wgray_next   = PW'(bin2gray(32'(wbin_next)));
  assign rq_bin       = PW'(gray2bin(32'(rq)));
  assign w_level_next = wbin_next - rq_bin;
  assign addr_w       = wbin[ADDR_W-1:0];

  always_ff @(posedge w_clk or negedge reset_n) begin
    if (!reset_n) begin
      wbin        <= '0;
      wgray       <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      w_level     <= '0;
      overflow    <= 1'b0;
    end else begin
      wbin        <= wbin_next;
      wgray       <= wgray_next;
      // Full when the writer is exactly one lap ahead of the synchronised reader.
      full        <= (wgray_next == {~rq[PW-1:PW-2], rq[PW-3:0]});
      almost_full <= (w_level_next >= AF_LVL);
      w_level     <= w_level_next;
`ifdef AFIFO_ERR_STICKY_EN
      overflow    <= overflow | (wr & full);
`else
      overflow    <= wr & full;
`endif
    end
  end

  // read domain
  assign rd_enable    = rd & ~empty;
  assign rbin_next    = rbin + PW'(rd_enable);
  assign rgray_next   = PW'(bin2gray(32'(rbin_next)));
  assign wq_bin       = PW'(gray2bin(32'(wq)));
  assign r_level_next = wq_bin - rbin_next;
  assign addr_r       = rbin[ADDR_W-1:0];

  always_ff @(posedge r_clk or negedge reset_n) begin
    if (!reset_n) begin
      rbin         <= '0;
      rgray        <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      r_level      <= '0;
      underflow    <= 1'b0;
    end else begin
      rbin         <= rbin_next;
      rgray        <= rgray_next;
      empty        <= (rgray_next == wq);
      almost_empty <= (r_level_next <= AE_LVL);
      r_level      <= r_level_next;
`ifdef AFIFO_ERR_STICKY_EN
      underflow    <= underflow | (rd & empty);
`else
      underflow    <= rd & empty;
`endif
    end
  end

  // Only the registered Gray pointers cross; the other side sees them late, so flags stay pessimistic.
  afifo_gray_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_sync_w2r (
    .clk     (r_clk),
    .reset_n (reset_n),
    .d       (wgray),
    .q       (wq)
  );

  afifo_gray_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_sync_r2w (
    .clk     (w_clk),
    .reset_n (reset_n),
    .d       (rgray),
    .q       (rq)
  );

endmodule

// File: tb/tb_afifo_ctl_lvl.sv
// Directed and randomized checks of afifo_ctl_lvl against an occupancy/queue reference model.
module tb_afifo_ctl_lvl;

  localparam int DEPTH = 16;
`ifdef AFIFO_ERR_STICKY_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic reset_n, r_clk, w_clk, wr, rd, wr3, rd3;
  int   w_half = 5;
  int   r_half = 7;

  logic [3:0] addr_w, addr_r, addr_w3, addr_r3;
  logic       we_enable, rd_enable, full, empty, almost_full, almost_empty, overflow, underflow;
  logic       we_enable3, rd_enable3, full3, empty3, almost_full3, almost_empty3, overflow3, underflow3;
  logic [4:0] w_level, r_level, w_level3, r_level3;

  afifo_ctl_lvl dut (
    .reset_n(reset_n), .r_clk(r_clk), .w_clk(w_clk), .wr(wr), .rd(rd),
    .addr_w(addr_w), .addr_r(addr_r), .we_enable(we_enable), .rd_enable(rd_enable),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .w_level(w_level), .r_level(r_level), .overflow(overflow), .underflow(underflow)
  );

  afifo_ctl_lvl #(.SYNC_STAGES(3)) dut3 (
    .reset_n(reset_n), .r_clk(r_clk), .w_clk(w_clk), .wr(wr3), .rd(rd3),
    .addr_w(addr_w3), .addr_r(addr_r3), .we_enable(we_enable3), .rd_enable(rd_enable3),
    .full(full3), .empty(empty3), .almost_full(almost_full3), .almost_empty(almost_empty3),
    .w_level(w_level3), .r_level(r_level3), .overflow(overflow3), .underflow(underflow3)
  );

  initial begin w_clk = 1'b0; forever #(w_half) w_clk = ~w_clk; end
  initial begin r_clk = 1'b0; forever #(r_half) r_clk = ~r_clk; end

  int total = 0;
  int bad   = 0;

  // reference model: true occupancy, FIFO contents in order, and a copy of the RAM
  int occ = 0;
  int wseq = 0;
  int rcnt = 0;
  int q[$];
  int mem [DEPTH];
  int n2, n3;
  time t_end;
  logic we_s, re_s;
  logic [3:0] wa_s;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; wr = 1'b0; rd = 1'b0; wr3 = 1'b0; rd3 = 1'b0;
    #23;
    reset_n = 1'b1;
    occ = 0;
    q.delete();
  endtask

  initial begin
    do_reset();
    repeat (2) @(posedge w_clk);
    #1;
    check("rst_empty", empty, 1);        check("rst_aempty", almost_empty, 1);
    check("rst_full", full, 0);          check("rst_afull", almost_full, 0);
    check("rst_wlvl", w_level, 0);       check("rst_rlvl", r_level, 0);
    check("rst_addr_w", addr_w, 0);      check("rst_addr_r", addr_r, 0);
    check("rst_ovf", overflow, 0);       check("rst_unf", underflow, 0);

    // fill with 16 writes, then one rejected write
    @(negedge w_clk); wr = 1'b1;
    for (int k = 1; k <= DEPTH; k++) begin
      @(posedge w_clk); #1;
      check("fill_wlvl", w_level, k);
      check("fill_afull", almost_full, (k >= 14));
      check("fill_full", full, (k == DEPTH));
      check("fill_addr_w", addr_w, k % DEPTH);
    end
    check("full_we_off", we_enable, 0);
    check("full_ovf_pre", overflow, 0);
    @(posedge w_clk); #1;
    check("ovf_set", overflow, 1);
    check("ovf_addr_hold", addr_w, 0);
    check("ovf_wlvl", w_level, DEPTH);
    wr = 1'b0;
    @(posedge w_clk); #1;
    check("ovf_after", overflow, STICKY);

    repeat (6) @(posedge r_clk); #1;
    check("sync_rlvl", r_level, DEPTH);
    check("sync_empty", empty, 0);
    check("sync_aempty", almost_empty, 0);

    // drain with 16 reads, then one rejected read
    @(negedge r_clk); rd = 1'b1;
    for (int k = 1; k <= DEPTH; k++) begin
      @(posedge r_clk); #1;
      check("drain_rlvl", r_level, DEPTH - k);
      check("drain_aempty", almost_empty, ((DEPTH - k) <= 2));
      check("drain_empty", empty, (k == DEPTH));
      check("drain_addr_r", addr_r, k % DEPTH);
    end
    check("empty_rd_off", rd_enable, 0);
    check("empty_unf_pre", underflow, 0);
    @(posedge r_clk); #1;
    check("unf_set", underflow, 1);
    check("unf_addr_hold", addr_r, 0);
    rd = 1'b0;
    @(posedge r_clk); #1;
    check("unf_after", underflow, STICKY);

    repeat (6) @(posedge w_clk); #1;
    check("drain_wlvl", w_level, 0);
    check("drain_full", full, 0);
    check("drain_afull", almost_full, 0);
    check("drain_ovf_hold", overflow, STICKY);

    // write-to-not-empty latency for 2 and 3 synchroniser stages
    @(negedge w_clk); wr = 1'b1; wr3 = 1'b1;
    @(posedge w_clk);
    fork begin #1; wr = 1'b0; wr3 = 1'b0; end join_none
    n2 = 0; n3 = 0;
    for (int e = 1; e <= 8; e++) begin
      @(posedge r_clk); #1;
      if (n2 == 0 && !empty)  n2 = e;
      if (n3 == 0 && !empty3) n3 = e;
    end
    check("lat_s2", (n2 == 3 || n2 == 4), 1);
    check("lat_s3", (n3 == 4 || n3 == 5), 1);

    // build 9 entries, consume 2, then reset asynchronously
    @(negedge w_clk); wr = 1'b1;
    repeat (8) @(posedge w_clk);
    #1; wr = 1'b0;
    check("pre_rst_addr_w", addr_w, 9);
    check("pre_rst_wlvl", w_level, 9);
    repeat (6) @(posedge r_clk); #1;
    check("pre_rst_rlvl", r_level, 9);
    @(negedge r_clk); rd = 1'b1;
    repeat (2) @(posedge r_clk);
    #1; rd = 1'b0;
    check("pre_rst_addr_r", addr_r, 2);
    check("pre_rst_rlvl2", r_level, 7);
    @(negedge w_clk); #2;
    reset_n = 1'b0;
    #1;
    check("arst_full", full, 0);        check("arst_afull", almost_full, 0);
    check("arst_empty", empty, 1);      check("arst_aempty", almost_empty, 1);
    check("arst_wlvl", w_level, 0);     check("arst_rlvl", r_level, 0);
    check("arst_addr_w", addr_w, 0);    check("arst_addr_r", addr_r, 0);
    check("arst_ovf", overflow, 0);     check("arst_unf", underflow, 0);
    #20;
    reset_n = 1'b1;
    @(negedge w_clk); wr = 1'b1; #1;
    check("post_rst_we", we_enable, 1);
    check("post_rst_addr_w", addr_w, 0);
    @(posedge w_clk); #1;
    wr = 1'b0;
    check("post_rst_addr_w1", addr_w, 1);
    check("post_rst_wlvl", w_level, 1);

    // randomized traffic at 7:3 and 3:7 clock ratios
    for (int ph = 0; ph < 2; ph++) begin
      w_half = (ph == 0) ? 7 : 3;
      r_half = (ph == 0) ? 3 : 7;
      do_reset();
      rcnt  = 0;
      t_end = $time + 6000;
      fork
        begin
          while ($time < t_end) begin
            @(negedge w_clk);
            wr = ($urandom_range(0, 99) < 60);
            #1;
            we_s = we_enable; wa_s = addr_w;
            if (we_s) check("rnd_no_write_when_full", (occ < DEPTH), 1);
            if (occ == DEPTH) check("rnd_full_when_full", full, 1);
            check("rnd_wlvl_pess", (w_level >= occ && w_level <= DEPTH), 1);
            check("rnd_full_vs_lvl", full, (w_level == 5'd16));
            check("rnd_afull_vs_lvl", almost_full, (w_level >= 5'd14));
            @(posedge w_clk);
            if (we_s) begin
              mem[wa_s] = wseq; q.push_back(wseq); wseq++; occ++;
            end
          end
          wr = 1'b0;
        end
        begin
          while ($time < t_end) begin
            @(negedge r_clk);
            rd = ($urandom_range(0, 99) < 60);
            #1;
            re_s = rd_enable;
            if (re_s) begin
              check("rnd_no_read_when_empty", (occ > 0), 1);
              if (q.size() > 0) check("rnd_data_order", mem[addr_r], q[0]);
            end
            if (occ == 0) check("rnd_empty_when_empty", empty, 1);
            check("rnd_rlvl_pess", (r_level <= occ), 1);
            check("rnd_empty_vs_lvl", empty, (r_level == 5'd0));
            check("rnd_aempty_vs_lvl", almost_empty, (r_level <= 5'd2));
            @(posedge r_clk);
            if (re_s && q.size() > 0) begin
              void'(q.pop_front()); occ--; rcnt++;
            end
          end
          rd = 1'b0;
        end
      join
      check("rnd_two_wraps", (rcnt >= 4 * DEPTH), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/afifo_ctl_lvl.md
Name: afifo_ctl_lvl

Overview:
- Control unit for a dual-clock FIFO. Generates binary read/write RAM addresses, enables, registered full/empty flags, almost-full/almost-empty flags, per-domain fill levels and overflow/underflow error flags.
- Pointers cross domains as Gray code through a parametrised N-stage synchroniser.
- Sits between producer/consumer logic and an external dual-port RAM (DEPTH = 2**ADDR_W).

Parameters:
- ADDR_W, 4, RAM address width; DEPTH = 2**ADDR_W; ADDR_W >= 2.
- SYNC_STAGES, 2, flop stages per crossing pointer; SYNC_STAGES >= 2.
- AF_THRESH, DEPTH-2, almost_full asserts when w_level >= AF_THRESH.
- AE_THRESH, 2, almost_empty asserts when r_level <= AE_THRESH.
- Constraint: 0 < AE_THRESH < AF_THRESH <= DEPTH; violation stops elaboration via generate-time check.

Ports:
- reset_n  in  1  reset; asynchronous, active-low; resets both domains.
- r_clk  in  1  read-domain clock.
- w_clk  in  1  write-domain clock.
- wr  in  1  write request (w_clk).
- rd  in  1  read request (r_clk).
- addr_w  out  ADDR_W  binary RAM write address.
- addr_r  out  ADDR_W  binary RAM read address.
- we_enable  out  1  wr & ~full; RAM write strobe.
- rd_enable  out  1  rd & ~empty; RAM read strobe.
- full  out  1  registered, w_clk.
- empty  out  1  registered, r_clk.
- almost_full  out  1  registered, w_clk.
- almost_empty  out  1  registered, r_clk.
- w_level  out  ADDR_W+1  pessimistic occupancy seen by the writer.
- r_level  out  ADDR_W+1  pessimistic occupancy seen by the reader.
- overflow  out  1  wr while full (w_clk).
- underflow  out  1  rd while empty (r_clk).

Behaviour:
- Pointers:
  - Each pointer is ADDR_W+1 bits, held as a binary register plus a Gray register. Gray = bin ^ (bin>>1).
  - The MSB is the wrap bit. addr_* = bin[ADDR_W-1:0].
  - A pointer increments by 1 on its own clock edge when its enable is high. It wraps modulo 2**(ADDR_W+1).
- Synchronisers:
  - Write Gray pointer passes through SYNC_STAGES r_clk flops to give wq.
  - Read Gray pointer passes through SYNC_STAGES w_clk flops to give rq.
  - Only Gray registers cross domains; no combinational logic precedes the first flop.
- Flags use next pointer values, so they are valid on the same edge as the pointer update:
  - full <= (wgray_next == {~rq[ADDR_W:ADDR_W-1], rq[ADDR_W-2:0]}).
  - empty <= (rgray_next == wq).
- Levels and almost flags:
  - w_level <= wbin_next - gray2bin(rq), modulo 2**(ADDR_W+1). Range 0..DEPTH.
  - r_level <= gray2bin(wq) - rbin_next, same rules.
  - almost_full <= (w_level_next >= AF_THRESH).
  - almost_empty <= (r_level_next <= AE_THRESH).
- Latency:
  - A write deasserts empty and raises r_level SYNC_STAGES+1 r_clk edges after the write edge; allow +1 edge of metastability uncertainty.
  - Reads affect full and w_level symmetrically in the w_clk domain.
- Boundaries:
  - wr while full: no pointer change, we_enable=0, overflow set.
  - rd while empty: no pointer change, rd_enable=0, underflow set.
  - Last write makes full=1 on that same edge. Last read makes empty=1 on that same edge.
  - Concurrent rd/wr in different domains are independent. Flags are pessimistic only: never a false not-full or a false not-empty.
- Reset values:
  - Asynchronous; all pointers, synchroniser flops and levels = 0.
  - empty=1, almost_empty=1, full=0, almost_full=0, overflow=underflow=0.
  - Reset asserted mid-operation discards all contents immediately; the FIFO reads as empty after reset release.

Optional Feature:
- AFIFO_ERR_STICKY_EN defined: overflow and underflow are sticky. Once set, they hold until reset_n.
- Not defined: each is a single-cycle pulse on every rejected request edge.

Decomposition:
- Shared package afifo_pkg holds:
  - the gray2bin / bin2gray functions;
  - the DEPTH derivation;
  - the minimum SYNC_STAGES constant (2).
- One sub-module: afifo_gray_sync. Parameters WIDTH and STAGES, async active-low reset. It is instantiated twice, once per crossing.

Test Plan:
- Reset release, no requests -> empty=1, almost_empty=1, full=0, levels=0, addr_w=addr_r=0.
- ADDR_W=4, 16 writes, no reads -> almost_full rises at the 14th write edge, full rises at the 16th, w_level=16. 17th wr -> we_enable=0, addr_w stays 0, overflow=1.
- From full, 16 reads -> empty=1 on the 16th read edge, r_level=0. Extra rd -> rd_enable=0, underflow=1 (sticky with AFIFO_ERR_STICKY_EN, else 1-cycle pulse).
- Single write into empty FIFO, SYNC_STAGES=2 -> empty deasserts 3 (max 4) r_clk edges later. Repeat with SYNC_STAGES=3 -> 4 (max 5).
- w_clk:r_clk = 7:3 and 3:7, 1000 random wr/rd with scoreboard -> data order preserved through 2+ pointer wraps. Never a write when truly full, never a read when truly empty.
- reset_n pulsed low with 9 entries stored -> all outputs return to reset values asynchronously; after release the next write lands at addr_w=0.
